// File: rtl/booth_sequencer.sv
// booth_sequencer: radix-2 Booth signed multiplier, one step per clock.
// The request is accepted on a ready/valid handshake, WIDTH steps run, and
// the product is held until it is consumed. Abort cancels a running multiply.
module booth_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic                 abort,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    // Counter is sized to hold WIDTH itself, so it never wraps during a run.
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH:0]   a_q, a_d;      // accumulator, one guard bit for M = -2^(WIDTH-1)
    logic [WIDTH:0]   mr_q;          // sign-extended multiplicand
    logic [WIDTH-1:0] qr_q, qr_d;    // multiplier, shifts out as product low half
    logic             q1_q, q1_d;    // Booth history bit
    logic [CW-1:0]    cnt_q;
    logic             in_ready_q;
    logic             busy_q;
    logic             out_valid_q;

    logic [WIDTH:0]   addend;
    logic             carry_in;
    logic [WIDTH:0]   sum;

    // Booth step datapath: conditional add/subtract of Mr, then arithmetic shift.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        addend   = '0;
        carry_in = 1'b0;
        unique case ({qr_q[0], q1_q})
            2'b01: addend = mr_q;
            2'b10: begin
                addend   = ~mr_q;
                carry_in = 1'b1;
            end
            default: ;
        endcase
        sum  = a_q + addend + {{WIDTH{1'b0}}, carry_in};
        a_d  = {sum[WIDTH], sum[WIDTH:1]};
        qr_d = {sum[0], qr_q[WIDTH-1:1]};
        q1_d = qr_q[0];
    end

    // Control FSM and datapath registers; handshake flags are registered with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            mr_q        <= '0;
            qr_q        <= '0;
            q1_q        <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples the
            // pre-edge values, matching the hardware and avoiding sim races.
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= RUN;
                        a_q        <= '0;
                        mr_q       <= {multiplicand[WIDTH-1], multiplicand};
                        qr_q       <= multiplier;
                        q1_q       <= 1'b0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort) begin
                        // Abort wins even on the final step.
                        state_q    <= IDLE;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                    end else begin
                        a_q   <= a_d;
                        qr_q  <= qr_d;
                        q1_q  <= q1_d;
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == LAST_STEP) begin
                            state_q     <= DONE;
                            busy_q      <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // Datapath is frozen here, so product holds under back-pressure.
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign product   = {a_q[WIDTH-1:0], qr_q};

endmodule

// File: tb/tb_booth_sequencer.sv
// Testbench for booth_sequencer: scoreboard of expected products, checked on out_valid.
module tb_booth_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        in_ready;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        abort;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] product;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    logic [63:0] sb[$];

    booth_sequencer #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .in_ready     (in_ready),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .abort        (abort),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .product      (product),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%h exp=0x%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] m, input logic [31:0] q);
        longint lm;
        longint lq;
        lm = longint'($signed(m));
        lq = longint'($signed(q));
        return 64'(lm * lq);
    endfunction

    // One multiply: pulse_a/pulse_b inject ignored starts, abort_at cancels (-1 = none),
    // stall holds out_ready low (with abort high) for that many DONE cycles.
    task automatic run_op(input logic [31:0] m, input logic [31:0] q, input logic [63:0] exp,
                          input int stall, input int abort_at, input int pulse_a, input int pulse_b);
        int   lat;
        bit   seen;
        logic [63:0] held;
        @(negedge clk);
        check("in_ready_idle", 64'(in_ready), 64'd1);
        multiplicand = m;
        multiplier   = q;
        start        = 1'b1;
        if (abort_at < 0) sb.push_back(exp);
        @(posedge clk);
        @(negedge clk);
        start        = 1'b0;
        multiplicand = $urandom;
        multiplier   = $urandom;
        check("busy_run", 64'(busy), 64'd1);
        check("in_ready_run", 64'(in_ready), 64'd0);
        lat = 0;
        while (lat < 100) begin
            if (lat + 1 == pulse_a || lat + 1 == pulse_b) begin
                start        = 1'b1;
                multiplicand = $urandom;
                multiplier   = $urandom;
            end
            abort = (lat + 1 == abort_at);
            @(posedge clk);
            lat++;
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            if (lat == abort_at) begin
                check("abort_busy", 64'(busy), 64'd0);
                check("abort_in_ready", 64'(in_ready), 64'd1);
                check("abort_out_valid", 64'(out_valid), 64'd0);
                seen = 1'b0;
                repeat (40) begin
                    @(posedge clk);
                    @(negedge clk);
                    if (out_valid) seen = 1'b1;
                end
                check("no_valid_after_abort", 64'(seen), 64'd0);
                return;
            end
            if (out_valid === 1'b1) break;
        end
        check("latency", 64'(lat), 64'd32);
        check("busy_done", 64'(busy), 64'd0);
        if (sb.size() == 0) begin
            check("sb_underflow", 64'd1, 64'd0);
        end else begin
            check("product", product, sb.pop_front());
        end
        held = product;
        repeat (stall) begin
            abort = 1'b1;
            start = 1'b1;
            @(posedge clk);
            @(negedge clk);
            abort = 1'b0;
            start = 1'b0;
            check("product_held", product, held);
            check("valid_held", 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_clear", 64'(out_valid), 64'd0);
        check("in_ready_back", 64'(in_ready), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rm, rq;
        rst_n        = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        out_ready    = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        #12;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_product", product, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(32'd3, 32'd5, 64'h0000_0000_0000_000F, 0, -1, -1, -1);
        run_op(32'hFFFF_FFF9, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6, 0, -1, -1, -1);
        run_op(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1, -1, -1, -1);
        run_op(32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000, 10, -1, -1, -1);
        run_op(32'h1234_5678, 32'h9ABC_DEF0, model(32'h1234_5678, 32'h9ABC_DEF0), 0, -1, 5, 20);
        run_op(32'd11, 32'd13, 64'd0, 0, 10, -1, -1);
        run_op(32'd11, 32'd13, 64'd0, 0, 32, -1, -1);

        // Asynchronous reset mid-run.
        @(negedge clk);
        multiplicand = 32'hDEAD_BEEF;
        multiplier   = 32'h0BAD_F00D;
        start        = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (17) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_product", product, 64'd0);
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_in_ready", 64'(in_ready), 64'd1);
        check("async_rst_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(32'd2, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 0, -1, -1, -1);

        for (int i = 0; i < 6; i++) begin
            rm = $urandom;
            rq = $urandom;
            run_op(rm, rq, model(rm, rq), int'($urandom_range(0, 3)), -1, -1, -1);
        end

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
